// File: rtl/tictactoe_board_ctrl.sv
// Tic-tac-toe board controller: accepts moves, keeps the registered 3x3 board,
// alternates turns and decides win/draw one cycle after each accepted move.
//
// state | meaning
// PLAY  | waiting for a move from the player indicated by turn
// CHECK | one cycle: evaluate the board for the player who just moved
// DONE  | game finished; moves ignored until new_game or reset
module tictactoe_board_ctrl #(
  parameter int FIRST_PLAYER = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       turn,
  output logic       move_ack,
  output logic       illegal_move,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [3:0] move_count
);

  localparam logic [1:0] PLAY  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic FIRST_TURN = (FIRST_PLAYER != 0);

  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;
  localparam logic [1:0] DRAW   = 2'b11;

  logic [1:0] state;
  logic [1:0] cells [0:8];
  logic [1:0] mark;
  logic [8:0] sel;
  logic [8:0] occupied;
  logic [8:0] own;
  logic       legal;
  logic       win;

  assign mark = turn ? MARK_O : MARK_X;

  // One-hot cell select; out-of-range positions select nothing.
  always_comb begin
    sel = '0;
    case (move_pos)
      4'd1: sel[0] = 1'b1;
      4'd2: sel[1] = 1'b1;
      4'd3: sel[2] = 1'b1;
      4'd4: sel[3] = 1'b1;
      4'd5: sel[4] = 1'b1;
      4'd6: sel[5] = 1'b1;
      4'd7: sel[6] = 1'b1;
      4'd8: sel[7] = 1'b1;
      4'd9: sel[8] = 1'b1;
      default: sel = '0;
    endcase
  end

  always_comb begin
    occupied = '0;
    own      = '0;
    for (int i = 0; i < 9; i++) begin
      occupied[i] = (cells[i] != 2'b00);
      own[i]      = (cells[i] == mark);
    end
  end

  assign legal = (|sel) && ((sel & occupied) == 9'd0);

  // turn still names the mover during CHECK, so own[] is the mover's marks.
  assign win = (own[0] & own[1] & own[2]) |
               (own[3] & own[4] & own[5]) |
               (own[6] & own[7] & own[8]) |
               (own[0] & own[3] & own[6]) |
               (own[1] & own[4] & own[7]) |
               (own[2] & own[5] & own[8]) |
               (own[0] & own[4] & own[8]) |
               (own[2] & own[4] & own[6]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PLAY;
      turn         <= FIRST_TURN;
      move_ack     <= 1'b0;
      illegal_move <= 1'b0;
      winner       <= 2'b00;
      game_over    <= 1'b0;
      move_count   <= 4'd0;
      for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
    end else begin
      move_ack     <= 1'b0;
      illegal_move <= 1'b0;
      if (new_game) begin
        state      <= PLAY;
        turn       <= FIRST_TURN;
        winner     <= 2'b00;
        game_over  <= 1'b0;
        move_count <= 4'd0;
        for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
      end else begin
        case (state)
          PLAY: begin
            if (move_valid) begin
              if (legal) begin
                for (int i = 0; i < 9; i++) begin
                  if (sel[i]) cells[i] <= mark;
                end
                move_count <= move_count + 4'd1;
                move_ack   <= 1'b1;
                state      <= CHECK;
              end else begin
                illegal_move <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (win) begin
              winner    <= mark;
              game_over <= 1'b1;
              state     <= DONE;
            end else if (move_count == 4'd9) begin
              winner    <= DRAW;
              game_over <= 1'b1;
              state     <= DONE;
            end else begin
              turn  <= ~turn;
              state <= PLAY;
            end
          end
          DONE:    state <= DONE;
          default: state <= PLAY;
        endcase
      end
    end
  end

  assign pos1 = cells[0];
  assign pos2 = cells[1];
  assign pos3 = cells[2];
  assign pos4 = cells[3];
  assign pos5 = cells[4];
  assign pos6 = cells[5];
  assign pos7 = cells[6];
  assign pos8 = cells[7];
  assign pos9 = cells[8];

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Bench for tictactoe_board_ctrl: directed games, pulses checked by a
// scoreboard monitor, status checked directly after each phase.
module tb_tictactoe_board_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game, move_valid;
  logic [3:0] move_pos;
  logic [1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       turn, move_ack, illegal_move, game_over;
  logic [1:0] winner;
  logic [3:0] move_count;

  logic       new_game_b, move_valid_b;
  logic [3:0] move_pos_b;
  logic [1:0] q1, q2, q3, q4, q5, q6, q7, q8, q9;
  logic       turn_b, move_ack_b, illegal_move_b, game_over_b;
  logic [1:0] winner_b;
  logic [3:0] move_count_b;

  always #5 clk = ~clk;

  tictactoe_board_ctrl #(.FIRST_PLAYER(0)) dut0 (
    .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos),
    .pos1(p1), .pos2(p2), .pos3(p3), .pos4(p4), .pos5(p5),
    .pos6(p6), .pos7(p7), .pos8(p8), .pos9(p9),
    .turn(turn), .move_ack(move_ack), .illegal_move(illegal_move),
    .winner(winner), .game_over(game_over), .move_count(move_count)
  );

  tictactoe_board_ctrl #(.FIRST_PLAYER(1)) dut1 (
    .clk(clk), .reset(reset), .new_game(new_game_b), .move_valid(move_valid_b),
    .move_pos(move_pos_b),
    .pos1(q1), .pos2(q2), .pos3(q3), .pos4(q4), .pos5(q5),
    .pos6(q6), .pos7(q7), .pos8(q8), .pos9(q9),
    .turn(turn_b), .move_ack(move_ack_b), .illegal_move(illegal_move_b),
    .winner(winner_b), .game_over(game_over_b), .move_count(move_count_b)
  );

  typedef struct {
    bit legal;
    int pos;
    int val;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] cell0(input int p);
    case (p)
      1: return p1;
      2: return p2;
      3: return p3;
      4: return p4;
      5: return p5;
      6: return p6;
      7: return p7;
      8: return p8;
      9: return p9;
      default: return 2'b00;
    endcase
  endfunction

  // Monitor: every ack/illegal pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (move_ack && illegal_move) chk("ack_and_illegal_same_cycle", 1, 0);
    if (move_ack || illegal_move) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, move_ack, illegal_move}, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("pulse_kind_pos%0d", e.pos), {31'd0, move_ack}, {31'd0, e.legal});
        if (e.legal) begin
          chk($sformatf("cell_written_pos%0d", e.pos), {30'd0, cell0(e.pos)}, e.val);
          chk($sformatf("count_at_ack_pos%0d", e.pos), {28'd0, move_count}, e.cnt);
        end
      end
    end
  end

  task automatic mv(input int pos, input bit legal, input int val, input int cnt);
    exp_t x;
    x.legal = legal; x.pos = pos; x.val = val; x.cnt = cnt;
    sb.push_back(x);
    move_valid = 1'b1;
    move_pos   = pos[3:0];
    @(negedge clk);
    move_valid = 1'b0;
    move_pos   = 4'd0;
    @(negedge clk);
  endtask

  task automatic ign(input int pos);
    move_valid = 1'b1;
    move_pos   = pos[3:0];
    @(negedge clk);
    move_valid = 1'b0;
    move_pos   = 4'd0;
    @(negedge clk);
  endtask

  task automatic ng();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic mv_b(input int pos);
    move_valid_b = 1'b1;
    move_pos_b   = pos[3:0];
    @(negedge clk);
    move_valid_b = 1'b0;
    move_pos_b   = 4'd0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int draw_seq[9]  = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    int win9_seq[9]  = '{1, 2, 3, 5, 4, 6, 8, 9, 7};
    int owin_seq[6]  = '{1, 5, 2, 3, 9, 7};

    reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
    new_game_b = 1'b0; move_valid_b = 1'b0; move_pos_b = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_board", {14'd0, p1, p2, p3, p4, p5, p6, p7, p8, p9}, 0);
    chk("reset_turn", {31'd0, turn}, 0);
    chk("reset_count", {28'd0, move_count}, 0);
    chk("reset_winner", {30'd0, winner}, 0);
    chk("reset_game_over", {31'd0, game_over}, 0);
    chk("reset_pulses", {30'd0, move_ack, illegal_move}, 0);
    chk("reset_turn_fp1", {31'd0, turn_b}, 1);

    // First move on the first edge after release.
    reset = 1'b0;
    mv(5, 1, 1, 1);
    chk("turn_after_first_move", {31'd0, turn}, 1);

    mv(5, 0, 0, 0);
    mv(0, 0, 0, 0);
    mv(12, 0, 0, 0);
    chk("illegal_pos5_kept", {30'd0, p5}, 1);
    chk("illegal_turn_kept", {31'd0, turn}, 1);
    chk("illegal_count_kept", {28'd0, move_count}, 1);
    chk("illegal_board_kept", {14'd0, p1, p2, p3, p4, p5, p6, p7, p8, p9}, 18'h00100);

    ng();
    chk("new_game_board", {14'd0, p1, p2, p3, p4, p5, p6, p7, p8, p9}, 0);
    chk("new_game_turn", {31'd0, turn}, 0);

    // Row win for X on the top row.
    mv(1, 1, 1, 1); mv(4, 1, 2, 2); mv(2, 1, 1, 3); mv(5, 1, 2, 4);
    chk("row_pre_game_over", {31'd0, game_over}, 0);
    mv(3, 1, 1, 5);
    chk("row_winner", {30'd0, winner}, 1);
    chk("row_game_over", {31'd0, game_over}, 1);
    ign(6);
    chk("done_ignore_pos6", {30'd0, p6}, 0);
    chk("done_ignore_count", {28'd0, move_count}, 5);

    // new_game and move_valid together in DONE.
    new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd6;
    @(negedge clk);
    new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
    chk("collide_board", {14'd0, p1, p2, p3, p4, p5, p6, p7, p8, p9}, 0);
    chk("collide_turn", {31'd0, turn}, 0);
    chk("collide_count", {28'd0, move_count}, 0);
    chk("collide_winner", {30'd0, winner}, 0);
    chk("collide_game_over", {31'd0, game_over}, 0);
    chk("collide_no_ack", {31'd0, move_ack}, 0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("draw_pre_game_over", {31'd0, game_over}, 0);
      mv(draw_seq[i], 1, (i % 2 == 1) ? 2 : 1, i + 1);
    end
    chk("draw_count", {28'd0, move_count}, 9);
    chk("draw_winner", {30'd0, winner}, 3);
    chk("draw_game_over", {31'd0, game_over}, 1);

    ng();
    for (int i = 0; i < 9; i++) mv(win9_seq[i], 1, (i % 2 == 1) ? 2 : 1, i + 1);
    chk("ninth_win_winner", {30'd0, winner}, 1);
    chk("ninth_win_count", {28'd0, move_count}, 9);

    ng();
    for (int i = 0; i < 6; i++) mv(owin_seq[i], 1, (i % 2 == 1) ? 2 : 1, i + 1);
    chk("o_win_winner", {30'd0, winner}, 2);
    chk("o_win_game_over", {31'd0, game_over}, 1);
    chk("o_win_count", {28'd0, move_count}, 6);

    // Asynchronous reset while in CHECK.
    ng();
    move_valid = 1'b1; move_pos = 4'd5;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    move_valid = 1'b0; move_pos = 4'd0;
    chk("async_pos5", {30'd0, p5}, 0);
    chk("async_ack", {31'd0, move_ack}, 0);
    chk("async_count", {28'd0, move_count}, 0);
    chk("async_turn", {31'd0, turn}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("async_after_count", {28'd0, move_count}, 0);
    chk("async_after_winner", {30'd0, winner}, 0);
    mv(5, 1, 1, 1);
    chk("async_after_turn", {31'd0, turn}, 1);

    // FIRST_PLAYER=1 instance: O wins, then collision restores turn=O.
    mv_b(1); mv_b(4); mv_b(2); mv_b(5); mv_b(3);
    chk("fp1_winner", {30'd0, winner_b}, 2);
    new_game_b = 1'b1; move_valid_b = 1'b1; move_pos_b = 4'd7;
    @(negedge clk);
    new_game_b = 1'b0; move_valid_b = 1'b0; move_pos_b = 4'd0;
    chk("fp1_collide_turn", {31'd0, turn_b}, 1);
    chk("fp1_collide_board", {14'd0, q1, q2, q3, q4, q5, q6, q7, q8, q9}, 0);
    chk("fp1_collide_count", {28'd0, move_count_b}, 0);
    chk("fp1_collide_winner", {30'd0, winner_b}, 0);
    chk("fp1_collide_pulses", {30'd0, move_ack_b, illegal_move_b}, 0);
    @(negedge clk);
    chk("fp1_collide_pulses_later", {30'd0, move_ack_b, illegal_move_b}, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tictactoe_board_ctrl.md
TICTACTOE_BOARD_CTRL -- requirements
Module: tictactoe_board_ctrl

Interface
REQ-001 The block SHALL have one parameter, FIRST_PLAYER, default 0, which selects the player who moves first after reset or new game (0 = X, 1 = O).
REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 new_game  input  1  synchronous request to clear the board and restart the game.
REQ-005 move_valid  input  1  single-cycle move request from the player whose turn it is.
REQ-006 move_pos  input  4  target cell, 1..9, row-major; sampled only when move_valid=1.
REQ-007 pos1..pos9  output  2 each  registered cell contents: 2'b00 empty, 2'b01 X, 2'b10 O; 2'b11 SHALL never be driven.
REQ-008 turn  output  1  player to move: 0 = X, 1 = O.
REQ-009 move_ack  output  1  one-cycle pulse when a move is written.
REQ-010 illegal_move  output  1  one-cycle pulse when a move is rejected.
REQ-011 winner  output  2  2'b00 none, 2'b01 X, 2'b10 O, 2'b11 draw.
REQ-012 game_over  output  1  high while the game is finished.
REQ-013 move_count  output  4  number of marks on the board, 0..9.

Function
REQ-014 The FSM SHALL have three states: PLAY, CHECK and DONE.
REQ-015 In PLAY, with move_valid=1, a legal move (move_pos in 1..9 and that cell 2'b00) SHALL take effect at the next edge: the cell is written with the mark of turn (X→01, O→10), move_count increments, move_ack pulses for one cycle, and the state becomes CHECK.
REQ-016 In PLAY, with move_valid=1, an illegal move (move_pos 0 or 10..15, or the cell is occupied) SHALL pulse illegal_move for one cycle; the board, turn, move_count and state remain unchanged.
REQ-017 CHECK SHALL last exactly one cycle and SHALL evaluate the registered board over the 8 lines (3 rows, 3 columns, 2 diagonals).
REQ-018 If the mover owns a complete line, CHECK SHALL set winner to the mover's mark, set game_over=1, and go to DONE.
REQ-019 If there is no line and move_count=9, CHECK SHALL set winner=2'b11, set game_over=1, and go to DONE.
REQ-020 Otherwise CHECK SHALL toggle turn and return to PLAY.
REQ-021 A win on the ninth move SHALL be reported as a win, not a draw.
REQ-022 move_valid in CHECK or DONE SHALL be ignored: no write, no move_ack, no illegal_move.
REQ-023 Latency from an accepted move: move_ack and the cell are visible 1 cycle after the request edge; turn, winner and game_over are updated 2 cycles after it; the next move is acceptable from cycle 2.
REQ-024 new_game=1 in any state SHALL, at the next edge, take effect as follows:
- all cells become 2'b00;
- move_count becomes 0;
- winner becomes 2'b00 and game_over becomes 0;
- turn becomes FIRST_PLAYER;
- the state becomes PLAY.
REQ-025 new_game SHALL take priority over a simultaneous move_valid; that move is discarded without move_ack or illegal_move.
REQ-026 move_ack and illegal_move SHALL never be high in the same cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 Reset SHALL immediately, regardless of clk, force the following, including mid-game or during CHECK:
- all cells to 2'b00;
- turn to FIRST_PLAYER;
- move_ack, illegal_move and game_over to 0;
- winner to 2'b00 and move_count to 0;
- the state to PLAY.
REQ-029 The first move SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-030 Legal move: after reset, move 5 → pos5=01, move_ack=1 for 1 cycle, move_count=1; turn=1 two cycles after the request.
REQ-031 Illegal move: after move 5, O plays 5, then O plays 0 and 12 → illegal_move pulses each time; board, turn=1 and move_count=1 are unchanged.
REQ-032 Row win: X plays 1,2,3 and O plays 4,5 → after the CHECK for cell 3, winner=01 and game_over=1; a further move_valid is ignored.
REQ-033 Draw: the sequence X1 O2 X3 O5 X4 O6 X8 O7 X9 → move_count=9, winner=11, game_over=1.
REQ-034 Collision: new_game and move_valid asserted together in DONE → board cleared, turn=FIRST_PLAYER, no move_ack; repeat with FIRST_PLAYER=1 so that turn=1.
REQ-035 Asynchronous reset: assert reset between clock edges during CHECK → outputs clear immediately, with no further pulse after release.
